// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: ALU ops, opcode/funct values,
// instruction classes, FSM states and the decoder result record.
package alu_ctrl_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_NOR  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_ZERO = 3'b111;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [2:0] {CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BEQ, CLS_BNE, CLS_ILL} cls_e;

    // Retire/abort cycles are IDLE cycles carrying registered pulses.
    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM} state_e;

    typedef struct packed {
        logic [2:0] alu_ctr;
        cls_e       cls;
        logic       src_imm;
        logic       reg_dst_rd;
    } dec_t;

endpackage

// File: rtl/alu_ctr_decode.sv
// Combinational instruction classifier: (opcode, funct) -> ALU op, class and
// operand/destination selects. Unknown encodings classify as CLS_ILL.
module alu_ctr_decode
    import alu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec = '{alu_ctr: ALU_ZERO, cls: CLS_ILL, src_imm: 1'b0, reg_dst_rd: 1'b0};
        case (opcode)
            OPC_RTYPE: begin
                dec.cls        = CLS_ALU;
                dec.reg_dst_rd = 1'b1;
                case (funct)
                    FUNCT_ADD: dec.alu_ctr = ALU_ADD;
                    FUNCT_SUB: dec.alu_ctr = ALU_SUB;
                    FUNCT_AND: dec.alu_ctr = ALU_AND;
                    FUNCT_OR:  dec.alu_ctr = ALU_OR;
                    FUNCT_XOR: dec.alu_ctr = ALU_XOR;
                    FUNCT_NOR: dec.alu_ctr = ALU_NOR;
                    FUNCT_SLT: dec.alu_ctr = ALU_SLT;
                    default: begin
                        dec.cls        = CLS_ILL;
                        dec.reg_dst_rd = 1'b0;
                    end
                endcase
            end
            OPC_ADDI: dec = '{alu_ctr: ALU_ADD, cls: CLS_ALU,   src_imm: 1'b1, reg_dst_rd: 1'b0};
            OPC_ANDI: dec = '{alu_ctr: ALU_AND, cls: CLS_ALU,   src_imm: 1'b1, reg_dst_rd: 1'b0};
            OPC_ORI:  dec = '{alu_ctr: ALU_OR,  cls: CLS_ALU,   src_imm: 1'b1, reg_dst_rd: 1'b0};
            OPC_XORI: dec = '{alu_ctr: ALU_XOR, cls: CLS_ALU,   src_imm: 1'b1, reg_dst_rd: 1'b0};
            OPC_SLTI: dec = '{alu_ctr: ALU_SLT, cls: CLS_ALU,   src_imm: 1'b1, reg_dst_rd: 1'b0};
            OPC_LW:   dec = '{alu_ctr: ALU_ADD, cls: CLS_LOAD,  src_imm: 1'b1, reg_dst_rd: 1'b0};
            OPC_SW:   dec = '{alu_ctr: ALU_ADD, cls: CLS_STORE, src_imm: 1'b1, reg_dst_rd: 1'b0};
            OPC_BEQ:  dec = '{alu_ctr: ALU_SUB, cls: CLS_BEQ,   src_imm: 1'b0, reg_dst_rd: 1'b0};
            OPC_BNE:  dec = '{alu_ctr: ALU_SUB, cls: CLS_BNE,   src_imm: 1'b0, reg_dst_rd: 1'b0};
            default:  ;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle ALU control sequencer: IDLE -> DECODE -> EXEC -> {retire | MEM} -> IDLE.
// All outputs are registered; retire/abort pulses coincide with instr_ready.
module alu_ctrl_fsm
    import alu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic [2:0] alu_ctr,
    output logic       alu_src_imm,
    output logic       reg_dst_rd,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       branch_taken,
    output logic       done,
    output logic       illegal,
    output logic       mem_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           state;
    logic [5:0]       op_q;
    logic [5:0]       funct_q;
    logic [CNT_W-1:0] cnt;
    dec_t             dec;

    alu_ctr_decode u_dec (
        .opcode (op_q),
        .funct  (funct_q),
        .dec    (dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            op_q         <= '0;
            funct_q      <= '0;
            cnt          <= '0;
            instr_ready  <= 1'b0;
            alu_ctr      <= ALU_ZERO;
            alu_src_imm  <= 1'b0;
            reg_dst_rd   <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_to_reg   <= 1'b0;
            reg_write    <= 1'b0;
            branch_taken <= 1'b0;
            done         <= 1'b0;
            illegal      <= 1'b0;
            mem_err      <= 1'b0;
        end else begin
            // Pulses and writeback qualifiers last exactly one cycle.
            reg_write    <= 1'b0;
            mem_to_reg   <= 1'b0;
            reg_dst_rd   <= 1'b0;
            branch_taken <= 1'b0;
            done         <= 1'b0;
            illegal      <= 1'b0;
            mem_err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    alu_ctr     <= ALU_ZERO;
                    alu_src_imm <= 1'b0;
                    if (instr_valid && instr_ready) begin
                        op_q        <= opcode;
                        funct_q     <= funct;
                        instr_ready <= 1'b0;
                        state       <= S_DECODE;
                    end else begin
                        instr_ready <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (dec.cls == CLS_ILL) begin
                        illegal     <= 1'b1;
                        instr_ready <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        alu_ctr     <= dec.alu_ctr;
                        alu_src_imm <= dec.src_imm;
                        state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (dec.cls)
                        CLS_ALU: begin
                            reg_write   <= 1'b1;
                            reg_dst_rd  <= dec.reg_dst_rd;
                            done        <= 1'b1;
                            instr_ready <= 1'b1;
                            state       <= S_IDLE;
                        end
                        CLS_BEQ, CLS_BNE: begin
                            branch_taken <= (dec.cls == CLS_BEQ) ? zero : ~zero;
                            done         <= 1'b1;
                            instr_ready  <= 1'b1;
                            state        <= S_IDLE;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            mem_read  <= (dec.cls == CLS_LOAD);
                            mem_write <= (dec.cls == CLS_STORE);
                            cnt       <= '0;
                            state     <= S_MEM;
                        end
                        default: begin
                            instr_ready <= 1'b1;
                            state       <= S_IDLE;
                        end
                    endcase
                end
                S_MEM: begin
                    // An ack on the final wait cycle still completes the access.
                    if (mem_ack) begin
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        done        <= 1'b1;
                        reg_write   <= (dec.cls == CLS_LOAD);
                        mem_to_reg  <= (dec.cls == CLS_LOAD);
                        instr_ready <= 1'b1;
                        state       <= S_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        mem_err     <= 1'b1;
                        instr_ready <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    instr_ready <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Bench for alu_ctrl_fsm: directed vector table, reset corner sequences and
// randomized instructions checked against a cycle-count reference model.
module tb_alu_ctrl_fsm;

    localparam int TMO = 16;
    localparam logic [2:0] KD = 3'b100;  // {done, illegal, mem_err}
    localparam logic [2:0] KI = 3'b010;
    localparam logic [2:0] KE = 3'b001;
    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_BNE = 4;

    logic       clk = 1'b0;
    logic       reset, instr_valid, zero, mem_ack;
    logic [5:0] opcode, funct;
    logic       instr_ready, alu_src_imm, reg_dst_rd, mem_read, mem_write;
    logic       mem_to_reg, reg_write, branch_taken, done, illegal, mem_err;
    logic [2:0] alu_ctr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] alu;
        logic       imm;
        int         pc;
        logic [2:0] kind;
        logic       rw, m2r, rd, bt;
        int         n;
        logic       mrd, mwr;
    } ref_t;

    typedef struct {
        string      nm;
        logic [5:0] op, fn;
        logic       zv;
        int         ack_at;
        ref_t       e;
    } vec_t;

    typedef struct {
        logic [5:0] op, fn;
        logic [2:0] alu;
        logic       imm;
        int         kind;
    } isa_t;

    isa_t isa[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    alu_ctrl_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .funct(funct), .zero(zero), .mem_ack(mem_ack),
        .alu_ctr(alu_ctr), .alu_src_imm(alu_src_imm), .reg_dst_rd(reg_dst_rd),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .branch_taken(branch_taken), .done(done),
        .illegal(illegal), .mem_err(mem_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic ref_t mk(input logic [2:0] alu, input logic imm, input int pc,
                                input logic [2:0] kind, input logic rw, input logic m2r,
                                input logic rd, input logic bt, input int n,
                                input logic mrd, input logic mwr);
        ref_t r;
        r.alu = alu; r.imm = imm; r.pc = pc; r.kind = kind;
        r.rw = rw; r.m2r = m2r; r.rd = rd; r.bt = bt;
        r.n = n; r.mrd = mrd; r.mwr = mwr;
        return r;
    endfunction

    // Reference: look the instruction up in the ISA table, then derive the
    // retire cycle and strobe count from the wait-time arithmetic.
    function automatic ref_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input logic zv, input int ack_at);
        ref_t r;
        int   k = -1;
        int   n;
        bit   acked;
        foreach (isa[i])
            if (isa[i].op == op && (op != 6'd0 || isa[i].fn == fn)) k = i;
        r = mk(3'b111, 1'b0, 2, KI, 0, 0, 0, 0, 0, 0, 0);
        if (k < 0) return r;
        r.alu  = isa[k].alu;
        r.imm  = isa[k].imm;
        r.pc   = 3;
        r.kind = KD;
        case (isa[k].kind)
            K_ALU: begin r.rw = 1'b1; r.rd = (op == 6'd0); end
            K_BEQ: r.bt = zv;
            K_BNE: r.bt = ~zv;
            default: begin
                acked  = (ack_at >= 0 && ack_at < TMO);
                n      = acked ? ack_at + 1 : TMO;
                r.n    = n;
                r.pc   = 3 + n;
                r.kind = acked ? KD : KE;
                r.mrd  = (isa[k].kind == K_LW);
                r.mwr  = (isa[k].kind == K_SW);
                r.rw   = acked && (isa[k].kind == K_LW);
                r.m2r  = r.rw;
            end
        endcase
        return r;
    endfunction

    task automatic add_isa(input logic [5:0] op, input logic [5:0] fn, input logic [2:0] alu,
                           input logic imm, input int kind);
        isa_t t;
        t.op = op; t.fn = fn; t.alu = alu; t.imm = imm; t.kind = kind;
        isa.push_back(t);
    endtask

    task automatic add_vec(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input logic zv, input int ack_at, input ref_t e);
        vec_t v;
        v.nm = nm; v.op = op; v.fn = fn; v.zv = zv; v.ack_at = ack_at; v.e = e;
        vecs.push_back(v);
    endtask

    task automatic check_reset_outs(input string nm);
        chk({nm, " alu_ctr"}, 32'(alu_ctr), 32'd7);
        chk({nm, " strobes"}, 32'({instr_ready, alu_src_imm, reg_dst_rd, mem_read, mem_write,
                                   mem_to_reg, reg_write, branch_taken, done, illegal, mem_err}), 32'd0);
    endtask

    task automatic wait_ready(input string nm);
        int t = 0;
        while (instr_ready !== 1'b1 && t < 50) begin
            tick;
            t++;
        end
        if (instr_ready !== 1'b1) chk({nm, " ready_wait"}, 32'd0, 32'd1);
    endtask

    // Issue one instruction and watch it until its retire/abort pulse.
    task automatic do_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                            input logic zv, input int ack_at, input ref_t e);
        int cyc = 1, n = 0, pc = -1;
        logic spur = 1'b0, alu_bad = 1'b0, typ_bad = 1'b0;
        logic [2:0] kind = '0;
        logic rw = 1'b0, m2r = 1'b0, rd = 1'b0, bt = 1'b0, strb = 1'b0, rdy = 1'b0;
        wait_ready(nm);
        instr_valid = 1'b1; opcode = op; funct = fn;
        zero = 1'($urandom); mem_ack = 1'($urandom);
        tick;
        instr_valid = 1'b0; opcode = 6'($urandom); funct = 6'($urandom);
        while (pc < 0 && cyc < 200) begin
            if (cyc == 1 && (alu_ctr !== 3'b111 || alu_src_imm !== 1'b0)) alu_bad = 1'b1;
            if (cyc >= 2 && (alu_ctr !== e.alu || alu_src_imm !== e.imm)) alu_bad = 1'b1;
            if (done === 1'b1 || illegal === 1'b1 || mem_err === 1'b1) begin
                pc = cyc; kind = {done, illegal, mem_err};
                rw = reg_write; m2r = mem_to_reg; rd = reg_dst_rd; bt = branch_taken;
                strb = mem_read | mem_write; rdy = instr_ready;
            end else begin
                if (reg_write | mem_to_reg | reg_dst_rd | branch_taken | instr_ready) spur = 1'b1;
                if (mem_read | mem_write) begin
                    n++;
                    if (mem_read !== e.mrd || mem_write !== e.mwr) typ_bad = 1'b1;
                end
                zero    = (cyc == 2) ? zv : 1'($urandom);
                mem_ack = (cyc >= 3) ? (cyc - 3 == ack_at) : 1'($urandom);
                tick;
                cyc++;
            end
        end
        mem_ack = 1'b0;
        chk({nm, " pulse_cycle"}, 32'(pc), 32'(e.pc));
        chk({nm, " pulse_kind"}, 32'(kind), 32'(e.kind));
        chk({nm, " reg_write"}, 32'(rw), 32'(e.rw));
        chk({nm, " mem_to_reg"}, 32'(m2r), 32'(e.m2r));
        chk({nm, " reg_dst_rd"}, 32'(rd), 32'(e.rd));
        chk({nm, " branch_taken"}, 32'(bt), 32'(e.bt));
        chk({nm, " ready_at_pulse"}, 32'(rdy), 32'd1);
        chk({nm, " strobe_at_pulse"}, 32'(strb), 32'd0);
        chk({nm, " strobe_cycles"}, 32'(n), 32'(e.n));
        chk({nm, " alu_trace_bad"}, 32'(alu_bad), 32'd0);
        chk({nm, " spurious_bad"}, 32'(spur), 32'd0);
        chk({nm, " strobe_type_bad"}, 32'(typ_bad), 32'd0);
    endtask

    initial begin
        logic [5:0] op, fn;
        logic       zv;
        int         ack_at, k;

        add_isa(6'h00, 6'h20, 3'b001, 1'b0, K_ALU);
        add_isa(6'h00, 6'h22, 3'b010, 1'b0, K_ALU);
        add_isa(6'h00, 6'h24, 3'b000, 1'b0, K_ALU);
        add_isa(6'h00, 6'h25, 3'b101, 1'b0, K_ALU);
        add_isa(6'h00, 6'h26, 3'b011, 1'b0, K_ALU);
        add_isa(6'h00, 6'h27, 3'b100, 1'b0, K_ALU);
        add_isa(6'h00, 6'h2A, 3'b110, 1'b0, K_ALU);
        add_isa(6'h08, 6'h00, 3'b001, 1'b1, K_ALU);
        add_isa(6'h0C, 6'h00, 3'b000, 1'b1, K_ALU);
        add_isa(6'h0D, 6'h00, 3'b101, 1'b1, K_ALU);
        add_isa(6'h0E, 6'h00, 3'b011, 1'b1, K_ALU);
        add_isa(6'h0A, 6'h00, 3'b110, 1'b1, K_ALU);
        add_isa(6'h23, 6'h00, 3'b001, 1'b1, K_LW);
        add_isa(6'h2B, 6'h00, 3'b001, 1'b1, K_SW);
        add_isa(6'h04, 6'h00, 3'b010, 1'b0, K_BEQ);
        add_isa(6'h05, 6'h00, 3'b010, 1'b0, K_BNE);

        add_vec("r_add",     6'h00, 6'h20, 1'b0, -1, mk(3'b001, 0, 3,  KD, 1, 0, 1, 0, 0,  0, 0));
        add_vec("r_sub",     6'h00, 6'h22, 1'b1, -1, mk(3'b010, 0, 3,  KD, 1, 0, 1, 0, 0,  0, 0));
        add_vec("r_slt",     6'h00, 6'h2A, 1'b0, -1, mk(3'b110, 0, 3,  KD, 1, 0, 1, 0, 0,  0, 0));
        add_vec("r_nor",     6'h00, 6'h27, 1'b0, -1, mk(3'b100, 0, 3,  KD, 1, 0, 1, 0, 0,  0, 0));
        add_vec("addi",      6'h08, 6'h22, 1'b0, -1, mk(3'b001, 1, 3,  KD, 1, 0, 0, 0, 0,  0, 0));
        add_vec("xori",      6'h0E, 6'h00, 1'b1, -1, mk(3'b011, 1, 3,  KD, 1, 0, 0, 0, 0,  0, 0));
        add_vec("beq_z1",    6'h04, 6'h00, 1'b1, -1, mk(3'b010, 0, 3,  KD, 0, 0, 0, 1, 0,  0, 0));
        add_vec("bne_z1",    6'h05, 6'h00, 1'b1, -1, mk(3'b010, 0, 3,  KD, 0, 0, 0, 0, 0,  0, 0));
        add_vec("bne_z0",    6'h05, 6'h00, 1'b0, -1, mk(3'b010, 0, 3,  KD, 0, 0, 0, 1, 0,  0, 0));
        add_vec("lw_ack3",   6'h23, 6'h00, 1'b0,  2, mk(3'b001, 1, 6,  KD, 1, 1, 0, 0, 3,  1, 0));
        add_vec("sw_tmo",    6'h2B, 6'h00, 1'b0, -1, mk(3'b001, 1, 19, KE, 0, 0, 0, 0, 16, 0, 1));
        add_vec("sw_ack15",  6'h2B, 6'h00, 1'b0, 15, mk(3'b001, 1, 19, KD, 0, 0, 0, 0, 16, 0, 1));
        add_vec("ill_op",    6'h3F, 6'h20, 1'b0, -1, mk(3'b111, 0, 2,  KI, 0, 0, 0, 0, 0,  0, 0));
        add_vec("r_add_b2b", 6'h00, 6'h20, 1'b0, -1, mk(3'b001, 0, 3,  KD, 1, 0, 1, 0, 0,  0, 0));
        add_vec("ill_funct", 6'h00, 6'h00, 1'b0, -1, mk(3'b111, 0, 2,  KI, 0, 0, 0, 0, 0,  0, 0));
        add_vec("lw_ack0",   6'h23, 6'h00, 1'b0,  0, mk(3'b001, 1, 4,  KD, 1, 1, 0, 0, 1,  1, 0));

        reset = 1'b1; instr_valid = 1'b1; opcode = 6'h00; funct = 6'h20;
        zero = 1'b0; mem_ack = 1'b0;
        repeat (3) tick;
        check_reset_outs("por");
        reset = 1'b0; instr_valid = 1'b0;
        tick;
        chk("ready_after_reset", 32'(instr_ready), 32'd1);

        foreach (vecs[i])
            do_instr(vecs[i].nm, vecs[i].op, vecs[i].fn, vecs[i].zv, vecs[i].ack_at, vecs[i].e);

        // Reset while a load is waiting in MEM drops it; the next load runs cleanly.
        wait_ready("rst_mid");
        instr_valid = 1'b1; opcode = 6'h23; funct = 6'h00;
        tick;
        instr_valid = 1'b0; mem_ack = 1'b0;
        repeat (3) tick;
        chk("rst_mid mem_read", 32'(mem_read), 32'd1);
        reset = 1'b1;
        tick;
        check_reset_outs("rst_mid");
        reset = 1'b0;
        tick;
        chk("rst_mid ready", 32'(instr_ready), 32'd1);
        do_instr("lw_after_rst", 6'h23, 6'h00, 1'b0, 1, model(6'h23, 6'h00, 1'b0, 1));

        repeat (40) begin
            if ($urandom_range(0, 4) == 0) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end else begin
                k  = int'($urandom_range(0, isa.size() - 1));
                op = isa[k].op;
                fn = (op == 6'd0) ? isa[k].fn : 6'($urandom);
            end
            zv     = 1'($urandom);
            ack_at = int'($urandom_range(0, 19));
            do_instr("rnd", op, fn, zv, ack_at, model(op, fn, zv, ack_at));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
